// File: rtl/bcd2binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Illegal digits (>9) skip conversion and report through error with a done pulse.
module bcd2binary_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic [BIN_W-1:0]    binary_out,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    if ((64'd1 << BIN_W) < pow10(DIGITS)) begin : g_width_check
        $error("BIN_W too small to hold the largest DIGITS-digit BCD value");
    end

    typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, bcd_shift;
    logic [BIN_W-1:0] bin_q, bin_d, bin_shift;
    logic [BIN_W-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic             bad_digit;

    // A digit is >= 8 exactly when its top bit is set; each digit is corrected independently.
    function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i+3]) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    assign bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};
    assign bcd_shift = correct_digits({1'b0, bcd_q[BCD_W-1:1]});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        out_d   = out_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_digit) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        bcd_d   = bcd_in;
                        bin_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                bcd_d = bcd_shift;
                bin_d = bin_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    out_d   = bin_shift;
                    state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign binary_out = out_q;
    assign error      = err_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FINISH);
endmodule

// File: tb/tb_bcd2binary_seq.sv
// Bench for bcd2binary_seq: scoreboard-checked vector table and sweep on the 2-digit
// instance, hand-written timing/corner sequences, and a 3-digit instance.
module tb_bcd2binary_seq;
    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bcd_in;
    logic [6:0]  binary_out;
    logic        busy, done, error;

    logic        start3;
    logic [11:0] bcd3;
    logic [9:0]  binary_out3;
    logic        busy3, done3, error3;

    bcd2binary_seq #(.DIGITS(2), .BIN_W(7)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .binary_out(binary_out), .busy(busy), .done(done), .error(error)
    );

    bcd2binary_seq #(.DIGITS(3), .BIN_W(10)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .bcd_in(bcd3),
        .binary_out(binary_out3), .busy(busy3), .done(done3), .error(error3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] bin;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] bcd;
        int         dec;
        logic       err;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[22];
    int         checks;
    int         errors;
    int         done_cnt;
    logic [6:0] last_bin;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse of the 2-digit instance pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 required no pending request");
            end else begin
                e = exp_q.pop_front();
                if (binary_out !== e.bin || error !== e.err) begin
                    errors++;
                    $display("FAIL scoreboard: got bin=%0d err=%0b expected bin=%0d err=%0b",
                             binary_out, error, e.bin, e.err);
                end
            end
        end
    end

    task automatic push_exp(input int dec, input logic e);
        exp_t x;
        x.err = e;
        x.bin = e ? last_bin : 7'(dec);
        if (!e) last_bin = 7'(dec);
        exp_q.push_back(x);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", (done_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic do_conv(input logic [7:0] b, input int dec, input logic e);
        int target;
        wait_idle();
        bcd_in = b;
        start  = 1'b1;
        push_exp(dec, e);
        target = done_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        wait_done(target);
    endtask

    initial begin
        int busy_n, done_at, err_n1, bin_n1, busy_n2, last_done, intervals_ok, win_dones;
        logic prev_busy;
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        last_bin = '0;
        rst = 1'b1; start = 1'b0; bcd_in = '0; start3 = 1'b0; bcd3 = '0;

        vecs[0]  = '{8'h00, 0, 1'b0};  vecs[1]  = '{8'h01, 1, 1'b0};
        vecs[2]  = '{8'h02, 2, 1'b0};  vecs[3]  = '{8'h03, 3, 1'b0};
        vecs[4]  = '{8'h04, 4, 1'b0};  vecs[5]  = '{8'h05, 5, 1'b0};
        vecs[6]  = '{8'h06, 6, 1'b0};  vecs[7]  = '{8'h07, 7, 1'b0};
        vecs[8]  = '{8'h08, 8, 1'b0};  vecs[9]  = '{8'h09, 9, 1'b0};
        vecs[10] = '{8'h10, 10, 1'b0}; vecs[11] = '{8'h11, 11, 1'b0};
        vecs[12] = '{8'h12, 12, 1'b0}; vecs[13] = '{8'h13, 13, 1'b0};
        vecs[14] = '{8'h14, 14, 1'b0}; vecs[15] = '{8'h15, 15, 1'b0};
        vecs[16] = '{8'h99, 99, 1'b0}; vecs[17] = '{8'h1A, 0, 1'b1};
        vecs[18] = '{8'h07, 7, 1'b0};  vecs[19] = '{8'hA0, 0, 1'b1};
        vecs[20] = '{8'h3F, 0, 1'b1};  vecs[21] = '{8'h80, 80, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_binary_out", binary_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);

        // 8'h99: latency and busy width
        wait_idle();
        bcd_in = 8'h99; start = 1'b1; push_exp(99, 1'b0);
        busy_n = 0; done_at = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            busy_n += int'(busy);
            if (done && done_at == 0) done_at = n;
        end
        chk("h99_busy_cycles", busy_n, 8);
        chk("h99_done_latency", done_at, 8);
        chk("h99_binary_out", binary_out, 99);
        chk("h99_error", error, 0);

        // illegal digit after 99: immediate done, result held
        wait_idle();
        bcd_in = 8'h1A; start = 1'b1; push_exp(0, 1'b1);
        done_at = 0; err_n1 = 0; bin_n1 = 0; busy_n2 = 1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0; err_n1 = int'(error); bin_n1 = int'(binary_out);
            end
            if (n == 2) busy_n2 = int'(busy);
            if (done && done_at == 0) done_at = n;
        end
        chk("h1A_done_latency", done_at, 1);
        chk("h1A_error", err_n1, 1);
        chk("h1A_binary_held", bin_n1, 99);
        chk("h1A_busy_falls", busy_n2, 0);

        wait_idle();
        bcd_in = 8'h07; start = 1'b1; push_exp(7, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("h07_error_cleared_on_accept", error, 0);
        wait_done(done_cnt + 1);

        foreach (vecs[i]) do_conv(vecs[i].bcd, vecs[i].dec, vecs[i].err);

        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                logic [3:0] t4, o4;
                t4 = 4'(t);
                o4 = 4'(o);
                do_conv({t4, o4}, t * 10 + o, 1'b0);
            end
        end

        // start held high; bcd_in toggled to 55 only while converting
        wait_idle();
        bcd_in = 8'h42; start = 1'b1; push_exp(42, 1'b0);
        prev_busy = 1'b0; last_done = 0; intervals_ok = 1; win_dones = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy && !prev_busy && n > 1) push_exp(42, 1'b0);
            if (done) begin
                win_dones++;
                if (last_done != 0 && n - last_done != 9) intervals_ok = 0;
                last_done = n;
            end
            prev_busy = busy;
            bcd_in = (busy && !done) ? 8'h55 : 8'h42;
        end
        start = 1'b0;
        chk("b2b_done_count", win_dones, 4);
        chk("b2b_interval_9", intervals_ok, 1);
        wait_done(done_cnt + 1);
        wait_idle();
        chk("b2b_binary_out", binary_out, 42);

        // reset during the third iteration of 8'h63
        bcd_in = 8'h63; start = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_bin = '0;
        chk("rst_mid_binary_out", binary_out, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_error", error, 0);
        busy_n = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            busy_n += int'(done);
        end
        chk("rst_mid_no_done", busy_n, 0);
        do_conv(8'h63, 63, 1'b0);

        // three-digit instance
        @(negedge clk);
        bcd3 = 12'h999; start3 = 1'b1;
        done_at = 0; bin_n1 = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) start3 = 1'b0;
            if (done3 && done_at == 0) begin
                done_at = n;
                bin_n1 = int'(binary_out3);
            end
        end
        chk("d3_999_latency", done_at, 11);
        chk("d3_999_binary_out", bin_n1, 999);
        chk("d3_999_error", error3, 0);

        bcd3 = 12'h9A0; start3 = 1'b1;
        done_at = 0; err_n1 = 0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start3 = 1'b0; err_n1 = int'(error3);
            end
            if (done3 && done_at == 0) done_at = n;
        end
        chk("d3_9A0_done_latency", done_at, 1);
        chk("d3_9A0_error", err_n1, 1);
        chk("d3_9A0_binary_held", binary_out3, 999);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd2binary_seq.md
# bcd2binary_seq

Sequential BCD-to-binary converter, the inverse of the lab's binary-to-BCD path. It accepts a packed multi-digit BCD value through a start/done handshake and converts it with the reverse double-dabble algorithm, one bit per clock. It also flags illegal BCD digits. It sits between BCD sources (switch/keypad digit entry, BCD display registers) and binary arithmetic logic.

## Interface
- DIGITS, 2: number of BCD digits on the input.
- BIN_W, 7: binary output width. Must satisfy 2^BIN_W ≥ 10^DIGITS (7 for 2 digits, 10 for 3). Elaboration fails otherwise.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in [3:0]; sampled only on the accepting edge.
- binary_out  output  BIN_W  registered result; holds until the next successful conversion.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse marking completion (valid or error).
- error  output  1  high when the last accepted request had a digit > 9; cleared by the next accepted start.

## Operation
- States: IDLE, CONVERT, FINISH. busy = (state ≠ IDLE). done = (state == FINISH), Moore-decoded.
- IDLE, start=1, all digits ≤ 9:
  - Load the shift register {bcd_reg = bcd_in, bin_reg = 0}.
  - Set iteration counter = 0 and error = 0.
  - Go to CONVERT.
- IDLE, start=1, any digit > 9:
  - Set error = 1; binary_out is unchanged.
  - Go directly to FINISH.
- IDLE, start=0: hold all state.
- CONVERT, each edge performs one iteration:
  - Shift {bcd_reg, bin_reg} right by 1; the LSB of bcd_reg enters the MSB of bin_reg.
  - Then, for every 4-bit digit of the shifted bcd_reg, if the digit ≥ 8, subtract 3.
  - Increment the counter.
- CONVERT, last iteration (counter == BIN_W−1): load binary_out with the post-shift bin_reg and go to FINISH.
- FINISH: unconditionally go to IDLE after one cycle.
- Arithmetic:
  - Internal register width is 4*DIGITS + BIN_W.
  - Correction is applied per digit, independently and in parallel.
  - bcd_reg is all-zero after the final shift. Overflow cannot occur given the BIN_W rule.
- start while busy (CONVERT or FINISH) is ignored; no queuing. bcd_in changes after the accepting edge have no effect.
- Reset at any time:
  - Aborts any conversion; no done pulse is produced.
  - state=IDLE, counter=0, bcd_reg=0, bin_reg=0.

## Timing
- Reset values: binary_out=0, busy=0, done=0, error=0.
- Let edge k be the edge that samples start=1 in IDLE.
- Valid input:
  - Iterations occur on edges k+1 … k+BIN_W; binary_out updates on edge k+BIN_W.
  - done is high for exactly the cycle after edge k+BIN_W.
  - busy is high from edge k until edge k+BIN_W+1.
  - Latency from start sample to done is BIN_W+1 cycles (8 for defaults).
- Invalid input: error and busy rise at edge k; done is high in the following cycle; busy falls at edge k+1.
- binary_out and error are stable and valid whenever done=1.
- Back-to-back: with start held high, the next request is accepted on the edge leaving FINISH→IDLE plus one. Throughput is one conversion per BIN_W+2 cycles (valid) or per 2 cycles (invalid).

## Test plan
- Reset, then bcd_in=8'h99 with start pulsed -> done 8 cycles after the sampling edge, binary_out=7'd99, error=0, busy high for exactly 8 cycles.
- Round-trip with the lab's 4-bit binary-to-BCD range: bcd_in=8'h00…8'h15 (valid codes only) -> binary_out=0…15 respectively; then exhaustively sweep 8'h00…8'h99 -> binary_out equals the decimal value every time.
- After a successful 8'h99, apply bcd_in=8'h1A -> error=1, done one cycle after sampling, binary_out stays 99; the next start with 8'h07 -> error cleared on accept, binary_out=7.
- start held high continuously with bcd_in=8'h42 -> done pulses exactly every 9 cycles, no extra pulses, binary_out=42; toggling bcd_in to 8'h55 while busy has no effect on the in-flight result.
- Assert rst during the 3rd CONVERT iteration of 8'h63 -> next cycle all outputs are 0, no done pulse; a subsequent start with 8'h63 -> binary_out=63.
- DIGITS=3, BIN_W=10: bcd_in=12'h999 -> binary_out=10'd999 after 11 cycles; bcd_in=12'h9A0 -> error=1.
